// File: rtl/nand_gate.sv
// Bitwise 2-input NAND with combinational (X), one-cycle registered (Y)
// and Z_DEPTH-stage pipelined (Z) views of the same function.
`timescale 1ns/1ps

module nand_gate #(
    parameter int WIDTH   = 1,
    parameter int Z_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z
);

    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_zPipe [Z_DEPTH];

    assign w_nand = ~(A & B);
    assign X      = w_nand;

    // Reset value is all-ones, i.e. the NAND of idle all-zero inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= '1;
        end else begin
            r_y <= w_nand;
        end
    end

    // Stage 0 captures the live NAND; later stages shift it toward Z
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < Z_DEPTH; k++) begin
                r_zPipe[k] <= '1;
            end
        end else begin
            r_zPipe[0] <= w_nand;
            for (int k = 1; k < Z_DEPTH; k++) begin
                r_zPipe[k] <= r_zPipe[k-1];
            end
        end
    end

    assign Y = r_y;
    assign Z = r_zPipe[Z_DEPTH-1];

endmodule

// File: tb/tb_nand_gate.sv
// Directed and small-model checks of nand_gate in two configurations:
// WIDTH=1/Z_DEPTH=2 (dut0) and WIDTH=4/Z_DEPTH=3 (dut1).
`timescale 1ns/1ps

module tb_nand_gate;

    logic       clk;
    logic       rst;
    logic       a0, b0;
    logic       x0, y0, z0;
    logic [3:0] a1, b1;
    logic [3:0] x1, y1, z1;

    int errors;
    int checks;

    nand_gate #(.WIDTH(1), .Z_DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .A(a0), .B(b0), .X(x0), .Y(y0), .Z(z0)
    );

    nand_gate #(.WIDTH(4), .Z_DEPTH(3)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .X(x1), .Y(y1), .Z(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b);
        a0 = a;
        b0 = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Truth-table vectors for the combinational sweep: {A,B} and expected X
    logic [1:0] sweepIn  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       sweepExp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic expY, expZ0, expZ1, n;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a0 = 1'b0; b0 = 1'b0;
        a1 = 4'b0000; b1 = 4'b0000;

        #2;
        checkOutput("resetY0", {3'b0, y0}, 4'b0001);
        checkOutput("resetZ0", {3'b0, z0}, 4'b0001);
        checkOutput("resetY1", y1, 4'b1111);
        checkOutput("resetZ1", z1, 4'b1111);

        // Release between edges, then sweep the truth table before edge 1
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(sweepIn[i][1], sweepIn[i][0]);
            #0.5;
            checkOutput($sformatf("sweepX%0d", i), {3'b0, x0}, {3'b0, sweepExp[i]});
            checkOutput($sformatf("sweepYHeld%0d", i), {3'b0, y0}, 4'b0001);
        end

        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("latE1Y", {3'b0, y0}, 4'b0000);
        checkOutput("latE1Z", {3'b0, z0}, 4'b0001);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("latE2Y", {3'b0, y0}, 4'b0001);
        checkOutput("latE2Z", {3'b0, z0}, 4'b0000);

        applyStimulus(1'b1, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("streamY", {3'b0, y0}, 4'b0000);
        checkOutput("streamZ", {3'b0, z0}, 4'b0000);
        #2;
        rst = 1'b1;
        #0.1;
        checkOutput("asyncY", {3'b0, y0}, 4'b0001);
        checkOutput("asyncZ", {3'b0, z0}, 4'b0001);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("relE1Y", {3'b0, y0}, 4'b0000);
        checkOutput("relE1Z", {3'b0, z0}, 4'b0001);
        tick();
        checkOutput("relE2Z", {3'b0, z0}, 4'b0000);

        // Four-bit instance: dut1 inputs were all-zero, so every stage holds 1111
        a1 = 4'b1100;
        b1 = 4'b1010;
        #0.5;
        checkOutput("w4X", x1, 4'b0111);
        checkOutput("w4YPre", y1, 4'b1111);
        tick();
        checkOutput("w4Y", y1, 4'b0111);
        checkOutput("w4ZE1", z1, 4'b1111);
        tick();
        checkOutput("w4ZE2", z1, 4'b1111);
        tick();
        checkOutput("w4ZE3", z1, 4'b0111);
        #2;
        rst = 1'b1;
        #0.1;
        checkOutput("w4RstY", y1, 4'b1111);
        checkOutput("w4RstZ", z1, 4'b1111);

        // Random section: reference history starts from the reset state
        expY = 1'b1; expZ0 = 1'b1; expZ1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n = !(a0 && b0);
            #1;
            checkOutput($sformatf("rndX%0d", c), {3'b0, x0}, {3'b0, n});
            tick();
            expZ1 = expZ0;
            expZ0 = n;
            expY  = n;
            checkOutput($sformatf("rndY%0d", c), {3'b0, y0}, {3'b0, expY});
            checkOutput($sformatf("rndZ%0d", c), {3'b0, z0}, {3'b0, expZ1});
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
